dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder on the MEM-stage load/store port of the pipelined core.
//  Accepts one load/store request at a time and applies byte/half/word write enables.
//  Returns load data right-justified, so the core's sign/zero extension works on bits [N-1:0].
//  Models a wait-state SRAM and raises o_busy so the hazard unit can stall F/D/E/M.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte address of word 0
//  DEPTH_WORDS 4096           number of 32-bit words; power of two, >=2
//  LATENCY     1              wait cycles from accept to response; 1..15
// PORTS
//  clk        in   1   clock, rising edge
//  reset_x    in   1   asynchronous reset, active-low
//  i_req      in   1   request strobe; sampled only in IDLE
//  i_we       in   1   1=store, 0=load
//  i_addr     in   32  byte address
//  i_wdata    in   32  store data, right-justified
//  i_memSize  in   2   00=byte 01=half 10=word 11=reserved (treated as word)
//  o_busy     out  1   request in flight; core must hold MEM stage
//  o_valid    out  1   one-cycle pulse: response done (load data valid / store committed)
//  o_rdata    out  32  load data, right-justified, upper bits zero; held until next o_valid
//  o_fault    out  1   misaligned or out-of-range access; qualifies o_valid
// BEHAVIOUR
//  Reset: state=IDLE; o_busy=0, o_valid=0, o_rdata=0, o_fault=0; array contents undefined.
//  FSM IDLE -> WAIT -> RESP -> IDLE:
//   IDLE: on i_req=1, capture we/addr/wdata/size; load cnt=LATENCY-1; go WAIT; o_busy=1 the next cycle.
//   WAIT: decrement cnt each cycle; at cnt==0 go RESP.
//   RESP: perform array access (store writes lanes; load reads word); o_valid=1 for this cycle only; o_busy=0; next IDLE.
//  Total: accept edge -> o_valid asserted LATENCY+1 cycles later. o_busy rises the cycle after accept and falls in RESP.
//  Back-to-back: i_req seen in the cycle after RESP is accepted. i_req during WAIT/RESP is ignored.
//  Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits. off = addr[1:0].
//  Store lanes: byte wb=1<<off, data replicated to all lanes.
//   half: wb=4'b0011<<off. word: wb=4'b1111.
//  Load: o_rdata = (word>>(8*off)) masked to the size; upper bits zero.
//  Out of range (addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS): store dropped, load returns 0, o_fault=1.
//  Misaligned (half with off[0]=1, word with off!=0): behaviour set by DMEM_MISALIGN_FAULT_EN.
//  Reset mid-operation: FSM returns to IDLE immediately; no pending store reaches the array.
//  Simultaneous reset deassert and i_req: the request is accepted on the first edge after deassert.
// CONFIGURATION
//  `DMEM_MISALIGN_FAULT_EN defined: misaligned access has o_fault=1 in RESP; store dropped; o_rdata=0.
//  Not defined: addr[1:0] forced to the natural alignment (half: off&2'b10; word: 0).
//   Access proceeds, o_fault=0. Out-of-range fault is always active.
// STRUCTURE
//  Shared package/header dmem_pkg: FSM state encodings (IDLE/WAIT/RESP), MEMSIZE_B/H/W constants.
//  Also lane-mask function lanes(size,off).
//  Sub-module dmem_sram_bank: 32-bit x DEPTH_WORDS synchronous array, 4 byte write enables, registered read.
//  Top holds FSM, counter, range/alignment checks, lane shifting.
// TESTING
//  1 Reset: hold reset_x=0 with i_req=1 -> o_busy=0, o_valid=0, o_rdata=0 throughout.
//  2 Word store 32'hDEADBEEF at BASE+0x10, then word load, LATENCY=1.
//    -> o_rdata=32'hDEADBEEF; o_valid pulses 2 cycles after each accept; o_busy 1 cycle each.
//  3 Byte stores 0x11,0x22,0x33,0x44 at BASE+0x20..0x23, then word load -> 32'h44332211.
//    Half load at BASE+0x22 -> 32'h0000_4433.
//  4 LATENCY=4: load accepted -> o_busy high 4 cycles, o_valid 5 cycles after accept.
//    i_req pulses during WAIT are ignored.
//  5 Store at BASE+4*DEPTH_WORDS -> o_fault=1 with o_valid. Array unchanged (re-read word 0 value intact).
//  6 Word load at BASE+0x22: with FAULT_EN -> o_fault=1, o_rdata=0.
//    Without FAULT_EN -> word at BASE+0x20, o_fault=0.
//  7 Assert reset_x=0 in WAIT of a store -> IDLE immediately; later load of that addr shows old data.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM states, access-size codes and lane helpers for dmem_responder
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam logic [1:0] MEMSIZE_B = 2'b00;
    localparam logic [1:0] MEMSIZE_H = 2'b01;
    localparam logic [1:0] MEMSIZE_W = 2'b10;

    // Reserved size 2'b11 falls into the word case in both helpers.
    function automatic logic [3:0] lanes(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEMSIZE_B: lanes = 4'b0001 << off;
            MEMSIZE_H: lanes = 4'b0011 << off;
            default:   lanes = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        case (size)
            MEMSIZE_B: replicate = {4{data[7:0]}};
            MEMSIZE_H: replicate = {2{data[15:0]}};
            default:   replicate = data;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// rtl/dmem_sram_bank.sv - 32-bit synchronous SRAM bank with byte write enables and registered read
module dmem_sram_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset_x,
    input  logic          we,
    input  logic [3:0]    wb,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage load/store responder with wait states; DMEM_MISALIGN_FAULT_EN selects fault-vs-align on misaligned access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_memSize,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_rdata,
    output logic        o_fault
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept;
    logic        mem_we;
    logic        mem_re;

    logic        in_range;
    logic        req_fault;
    logic [1:0]  req_off;

    logic          we_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          fault_q;

    logic [31:0] mem_rdata;
    logic [31:0] shifted;
    logic [31:0] load_data;

    always_comb begin
        in_range = ({1'b0, i_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, i_addr} < END_ADDR);
`ifdef DMEM_MISALIGN_FAULT_EN
        req_off   = i_addr[1:0];
        req_fault = !in_range
                  || ((i_memSize == MEMSIZE_H) && i_addr[0])
                  || (i_memSize[1] && (i_addr[1:0] != 2'b00));
`else
        req_fault = !in_range;
        case (i_memSize)
            MEMSIZE_B: req_off = i_addr[1:0];
            MEMSIZE_H: req_off = i_addr[1:0] & 2'b10;
            default:   req_off = 2'b00;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The read is launched on the last wait cycle so the registered SRAM
    // output is ready to be lane-shifted into o_rdata at the response edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        o_busy    = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            ST_WAIT: begin
                o_busy = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                    mem_re    = !we_q && !fault_q;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
                mem_we    = we_q && !fault_q;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            we_q    <= 1'b0;
            size_q  <= MEMSIZE_B;
            off_q   <= 2'b00;
            idx_q   <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
        end else if (accept) begin
            we_q    <= i_we;
            size_q  <= i_memSize;
            off_q   <= req_off;
            idx_q   <= AW'((i_addr - BASE_ADDR) >> 2);
            wdata_q <= i_wdata;
            fault_q <= req_fault;
        end
    end

    dmem_sram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk     (clk),
        .reset_x (reset_x),
        .we      (mem_we),
        .wb      (lanes(size_q, off_q)),
        .addr    (idx_q),
        .wdata   (replicate(size_q, wdata_q)),
        .re      (mem_re),
        .rdata   (mem_rdata)
    );

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            MEMSIZE_B: load_data = {24'd0, shifted[7:0]};
            MEMSIZE_H: load_data = {16'd0, shifted[15:0]};
            default:   load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            o_valid <= 1'b0;
            o_rdata <= '0;
            o_fault <= 1'b0;
        end else begin
            o_valid <= (state == ST_RESP);
            if (state == ST_RESP) begin
                o_fault <= fault_q;
                o_rdata <= (we_q || fault_q) ? 32'd0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench: LATENCY=1 and LATENCY=4 instances against a byte-array model
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 64;
    localparam logic [1:0]  SZ_B  = 2'b00;
    localparam logic [1:0]  SZ_H  = 2'b01;
    localparam logic [1:0]  SZ_W  = 2'b10;
    localparam logic [1:0]  SZ_R  = 2'b11;

    logic        clk = 1'b0;
    logic        reset_x = 1'b0;
    logic        req1 = 1'b0;
    logic        req4 = 1'b0;
    logic        i_we = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [1:0]  i_size = '0;

    logic        busy1, valid1, fault1;
    logic [31:0] rdata1;
    logic        busy4, valid4, fault4;
    logic [31:0] rdata4;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [4*DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [22];

    always #5 clk = ~clk;

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset_x(reset_x), .i_req(req1), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_memSize(i_size), .o_busy(busy1), .o_valid(valid1),
        .o_rdata(rdata1), .o_fault(fault1)
    );

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(4)) dut4 (
        .clk(clk), .reset_x(reset_x), .i_req(req4), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_memSize(i_size), .o_busy(busy4), .o_valid(valid4),
        .o_rdata(rdata4), .o_fault(fault4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-addressed model: range check, then fault or align-down, then little-endian access.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, output logic [31:0] rdata, output logic fault);
        longint a;
        longint base_l;
        int     n;
        int     off;
        a      = longint'({32'd0, addr});
        base_l = longint'({32'd0, BASE});
        n      = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
        rdata  = '0;
        fault  = 1'b0;
        if (a < base_l || a >= base_l + 4 * DEPTH) begin
            fault = 1'b1;
        end else if (a % n != 0) begin
`ifdef DMEM_MISALIGN_FAULT_EN
            fault = 1'b1;
`else
            a = a - (a % n);
`endif
        end
        if (!fault) begin
            off = int'(a - base_l);
            for (int i = 0; i < n; i++) begin
                if (we) model_mem[off + i] = wdata[8*i +: 8];
                else    rdata[8*i +: 8]    = model_mem[off + i];
            end
        end
    endtask

    // One transaction on both instances; req4 is pulsed again while dut4 is waiting.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic [31:0] exp_r, input logic exp_f,
                          input string tag);
        int v1_at = -1, v4_at = -1, v1_n = 0, v4_n = 0, b1 = 0, b4 = 0;
        logic [31:0] r1 = '0, r4 = '0;
        logic        f1 = 1'b0, f4 = 1'b0;
        i_we = we; i_addr = addr; i_wdata = wdata; i_size = size;
        req1 = 1'b1; req4 = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (busy1) b1++;
            if (busy4) b4++;
            if (valid1) begin v1_n++; if (v1_at < 0) begin v1_at = j; r1 = rdata1; f1 = fault1; end end
            if (valid4) begin v4_n++; if (v4_at < 0) begin v4_at = j; r4 = rdata4; f4 = fault4; end end
            req1 = 1'b0;
            req4 = (j == 0 || j == 1);
        end
        req4 = 1'b0;
        chk({tag, " lat1"}, v1_at, 2);
        chk({tag, " busy1"}, b1, 1);
        chk({tag, " vcnt1"}, v1_n, 1);
        chk({tag, " fault1"}, {31'd0, f1}, {31'd0, exp_f});
        chk({tag, " lat4"}, v4_at, 5);
        chk({tag, " busy4"}, b4, 4);
        chk({tag, " vcnt4"}, v4_n, 1);
        chk({tag, " fault4"}, {31'd0, f4}, {31'd0, exp_f});
        if (!we) begin
            chk({tag, " rdata1"}, r1, exp_r);
            chk({tag, " rdata4"}, r4, exp_r);
            chk({tag, " hold1"}, rdata1, exp_r);
            chk({tag, " hold4"}, rdata4, exp_r);
        end
    endtask

    initial begin
        logic [31:0] er;
        logic        ef;
        logic [31:0] a;
        logic        w;
        logic [1:0]  s;

        vecs[0]  = '{1'b1, 32'h1000_0010, 32'hDEAD_BEEF, SZ_W, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h1000_0010, 32'h0, SZ_W, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h1000_0020, 32'h0000_0011, SZ_B, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 32'h1000_0021, 32'h0000_0022, SZ_B, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 32'h1000_0022, 32'h0000_0033, SZ_B, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 32'h1000_0023, 32'h0000_0044, SZ_B, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h1000_0020, 32'h0, SZ_W, 32'h4433_2211, 1'b0};
        vecs[7]  = '{1'b0, 32'h1000_0022, 32'h0, SZ_H, 32'h0000_4433, 1'b0};
        vecs[8]  = '{1'b1, 32'h1000_0100, 32'hCAFE_F00D, SZ_W, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, 32'h1000_0000, 32'h0, SZ_W, 32'hC0DE_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0FFF_FFFC, 32'h0, SZ_W, 32'h0, 1'b1};
`ifdef DMEM_MISALIGN_FAULT_EN
        vecs[11] = '{1'b0, 32'h1000_0022, 32'h0, SZ_W, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 32'h1000_0023, 32'h0, SZ_H, 32'h0, 1'b1};
        vecs[19] = '{1'b1, 32'h1000_0031, 32'h0000_1234, SZ_H, 32'h0, 1'b1};
        vecs[20] = '{1'b0, 32'h1000_0030, 32'h0, SZ_W, 32'hC0DE_000C, 1'b0};
`else
        vecs[11] = '{1'b0, 32'h1000_0022, 32'h0, SZ_W, 32'h4433_2211, 1'b0};
        vecs[12] = '{1'b0, 32'h1000_0023, 32'h0, SZ_H, 32'h0000_4433, 1'b0};
        vecs[19] = '{1'b1, 32'h1000_0031, 32'h0000_1234, SZ_H, 32'h0, 1'b0};
        vecs[20] = '{1'b0, 32'h1000_0030, 32'h0, SZ_W, 32'hC0DE_1234, 1'b0};
`endif
        vecs[13] = '{1'b0, 32'h1000_0021, 32'h0, SZ_B, 32'h0000_0022, 1'b0};
        vecs[14] = '{1'b1, 32'h1000_0012, 32'h0000_ABCD, SZ_H, 32'h0, 1'b0};
        vecs[15] = '{1'b0, 32'h1000_0010, 32'h0, SZ_W, 32'hABCD_BEEF, 1'b0};
        vecs[16] = '{1'b0, 32'h1000_0010, 32'h0, SZ_R, 32'hABCD_BEEF, 1'b0};
        vecs[17] = '{1'b0, 32'h1000_0013, 32'h0, SZ_B, 32'h0000_00AB, 1'b0};
        vecs[18] = '{1'b0, 32'h1000_00FE, 32'h0, SZ_H, 32'h0000_C0DE, 1'b0};
        vecs[21] = '{1'b0, 32'h1000_00FF, 32'h0, SZ_B, 32'h0000_00C0, 1'b0};

        // Reset held with a pending request: everything stays quiet.
        i_we = 1'b1; i_addr = BASE; i_wdata = 32'hC0DE_0000; i_size = SZ_W;
        req1 = 1'b1; req4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst busy1", {31'd0, busy1}, 32'd0);
            chk("rst valid1", {31'd0, valid1}, 32'd0);
            chk("rst rdata1", rdata1, 32'd0);
            chk("rst busy4", {31'd0, busy4}, 32'd0);
            chk("rst valid4", {31'd0, valid4}, 32'd0);
            chk("rst rdata4", rdata4, 32'd0);
        end

        // Release reset with i_req already high: first edge must accept.
        reset_x = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            model_access(1'b1, BASE + 32'(4 * i), 32'hC0DE_0000 | 32'(i), SZ_W, er, ef);
            do_txn(1'b1, BASE + 32'(4 * i), 32'hC0DE_0000 | 32'(i), SZ_W, 32'h0, 1'b0, "init");
        end

        for (int i = 0; i < 22; i++) begin
            model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, er, ef);
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                   vecs[i].exp_rdata, vecs[i].exp_fault, $sformatf("vec%0d", i));
        end

        // Reset during WAIT of a store: the store must never land.
        i_we = 1'b1; i_addr = 32'h1000_0040; i_wdata = 32'h1234_5678; i_size = SZ_W;
        req1 = 1'b1; req4 = 1'b1;
        @(negedge clk);
        req1 = 1'b0; req4 = 1'b0;
        chk("abort wait1", {31'd0, busy1}, 32'd1);
        chk("abort wait4", {31'd0, busy4}, 32'd1);
        reset_x = 1'b0;
        #1;
        chk("abort busy1", {31'd0, busy1}, 32'd0);
        chk("abort busy4", {31'd0, busy4}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("abort valid1", {31'd0, valid1}, 32'd0);
        chk("abort valid4", {31'd0, valid4}, 32'd0);
        reset_x = 1'b1;
        do_txn(1'b0, 32'h1000_0040, 32'h0, SZ_W, 32'hC0DE_0010, 1'b0, "abort reread");

        // Back-to-back on dut1: next request raised in the o_valid cycle.
        i_we = 1'b0; i_addr = 32'h1000_0010; i_size = SZ_W; req1 = 1'b1; req4 = 1'b0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j == 0) begin
                req1 = 1'b0;
                chk("b2b busy a", {31'd0, busy1}, 32'd1);
            end
            if (j == 2) begin
                chk("b2b valid a", {31'd0, valid1}, 32'd1);
                chk("b2b rdata a", rdata1, 32'hABCD_BEEF);
                i_addr = 32'h1000_0020; req1 = 1'b1;
            end
            if (j == 3) begin
                req1 = 1'b0;
                chk("b2b busy b", {31'd0, busy1}, 32'd1);
                chk("b2b novalid", {31'd0, valid1}, 32'd0);
            end
            if (j == 5) begin
                chk("b2b valid b", {31'd0, valid1}, 32'd1);
                chk("b2b rdata b", rdata1, 32'h4433_2211);
            end
        end

        for (int t = 0; t < 200; t++) begin
            w = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'($urandom_range(1, 64));
                1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
                default: a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            endcase
            i_wdata = $urandom;
            model_access(w, a, i_wdata, s, er, ef);
            do_txn(w, a, i_wdata, s, er, ef, $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
